// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with status flags and condition test.
// Valid/ready handshake on both sides; holds up to two beats in flight.
module alu_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             u,
   input  logic             op1,
   input  logic             op0,
   input  logic             zx,
   input  logic             sw,
   input  logic [2:0]       cond,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             cond_true
);

   typedef struct packed {
      logic [WIDTH-1:0] xo;
      logic [WIDTH-1:0] yo;
      logic             u;
      logic             op1;
      logic             op0;
      logic [2:0]       cond;
   } s1_t;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic [3:0]       flags;
      logic [2:0]       cond;
   } s2_t;

   logic             s1_v;
   logic             s2_v;
   logic             s1_adv;
   logic             s2_adv;
   logic             in_fire;
   s1_t              s1_d;
   s1_t              s1_q;
   s2_t              s2_d;
   s2_t              s2_q;

   logic [WIDTH-1:0] xs;
   logic [WIDTH-1:0] ys;
   logic [WIDTH-1:0] b_arg;
   logic [WIDTH-1:0] addend;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic             add_ovf;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic             ovf;

   // S2 drains when empty or consumed; S1 moves on only into a free S2
   assign s2_adv   = ~s2_v | out_ready;
   assign s1_adv   = s1_v & s2_adv;
   assign in_ready = ~s1_v | s2_adv;
   assign in_fire  = in_valid & in_ready;

   // Operand prep: optional swap, then optional zeroing of X
   always_comb begin
      xs = sw ? y : x;
      ys = sw ? x : y;
      s1_d      = '0;
      s1_d.xo   = zx ? '0 : xs;
      s1_d.yo   = ys;
      s1_d.u    = u;
      s1_d.op1  = op1;
      s1_d.op0  = op0;
      s1_d.cond = cond;
   end

   // Execute: one adder covers add/sub/inc/dec, op1 selects invert+carry-in
   always_comb begin
      b_arg   = s1_q.op0 ? WIDTH'(1) : s1_q.yo;
      addend  = s1_q.op1 ? ~b_arg : b_arg;
      cin     = s1_q.op1;
      sum     = {1'b0, s1_q.xo} + {1'b0, addend}
              + {{WIDTH{1'b0}}, cin};
      add_ovf = (s1_q.xo[WIDTH-1] == addend[WIDTH-1])
              & (sum[WIDTH-1] != s1_q.xo[WIDTH-1]);
      res     = '0;
      carry   = 1'b0;
      ovf     = 1'b0;
      unique case (1'b1)
         s1_q.u: begin
            res   = sum[WIDTH-1:0];
            carry = sum[WIDTH];
            ovf   = add_ovf;
         end
         (~s1_q.u & ~s1_q.op1 & ~s1_q.op0):
            res = s1_q.xo & s1_q.yo;
         (~s1_q.u & ~s1_q.op1 & s1_q.op0):
            res = s1_q.xo | s1_q.yo;
         (~s1_q.u & s1_q.op1 & ~s1_q.op0):
            res = s1_q.xo ^ s1_q.yo;
         (~s1_q.u & s1_q.op1 & s1_q.op0):
            res = ~s1_q.xo;
         default: res = '0;
      endcase
      s2_d       = '0;
      s2_d.res   = res;
      s2_d.flags = {(res == '0), res[WIDTH-1], carry, ovf};
      s2_d.cond  = s1_q.cond;
   end

   // Stage 1: capture prepared operands when a beat is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v <= 1'b0;
         s1_q <= '0;
      end else begin
         if (in_ready) s1_v <= in_valid;
         if (in_fire)  s1_q <= s1_d;
      end
   end

   // Stage 2: capture result and flags when stage 1 hands over
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v <= 1'b0;
         s2_q <= '0;
      end else begin
         if (s2_adv) s2_v <= s1_v;
         if (s1_adv) s2_q <= s2_d;
      end
   end

   assign out_valid = s2_v;
   assign result    = s2_q.res;
   assign flags     = s2_q.flags;
   assign cond_true = (s2_q.cond[2] & s2_q.flags[2])
                    | (s2_q.cond[1] & s2_q.flags[3])
                    | (s2_q.cond[0] & ~s2_q.flags[2]
                                    & ~s2_q.flags[3]);

endmodule
